// File: rtl/alu_rs.sv
// -----------------------------------------------------------------------------
// alu_rs : reservation station for ALU-class instructions
//          (ARITH, ARITH_IMM, JAL, JALR, BRANCH, LUI, AUIPC).
//
// Holds issued instructions until both source operands are valid, snoops the
// ALU and LSB result broadcasts to capture pending operands, and dispatches at
// most one ready instruction per cycle to the ALU through registered outputs.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global ready; when low all state holds
//   rollback            misprediction flush (clears every entry)
//   issue*              new instruction from the decoder / issue logic
//   alu_result*         ALU result broadcast (valid, tag, value)
//   lsb_result*         LSB result broadcast (valid, tag, value)
//   rs_full             combinational: every entry is busy
//   alu_en ... rob_pos  registered dispatch bundle to the ALU
//
// Configuration
//   RS_FWD_ISSUE_EN     when defined, an operand issued not-ready whose tag
//                       matches a same-cycle broadcast is written as ready
//                       with the broadcast value.
// -----------------------------------------------------------------------------
module alu_rs #(
   parameter int RS_SIZE   = 16,
   parameter int ROB_POS_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 rollback,
   input  logic                 issue,
   input  logic [ROB_POS_W-1:0] issue_rob_pos,
   input  logic [6:0]           issue_opcode,
   input  logic [2:0]           issue_funct3,
   input  logic                 issue_funct7,
   input  logic                 issue_rs1_rdy,
   input  logic [31:0]          issue_rs1_val,
   input  logic [ROB_POS_W-1:0] issue_rs1_tag,
   input  logic                 issue_rs2_rdy,
   input  logic [31:0]          issue_rs2_val,
   input  logic [ROB_POS_W-1:0] issue_rs2_tag,
   input  logic [31:0]          issue_imm,
   input  logic [31:0]          issue_pc,
   input  logic                 alu_result,
   input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
   input  logic [31:0]          alu_result_val,
   input  logic                 lsb_result,
   input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
   input  logic [31:0]          lsb_result_val,
   output logic                 rs_full,
   output logic                 alu_en,
   output logic [6:0]           opcode,
   output logic [2:0]           funct3,
   output logic                 funct7,
   output logic [31:0]          val1,
   output logic [31:0]          val2,
   output logic [31:0]          imm,
   output logic [31:0]          pc,
   output logic [ROB_POS_W-1:0] rob_pos
);

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   logic [RS_SIZE-1:0]   busy_r;
   logic [RS_SIZE-1:0]   rs1_rdy_r;
   logic [RS_SIZE-1:0]   rs2_rdy_r;
   logic [6:0]           opcode_r  [RS_SIZE];
   logic [2:0]           funct3_r  [RS_SIZE];
   logic                 funct7_r  [RS_SIZE];
   logic [31:0]          rs1_val_r [RS_SIZE];
   logic [31:0]          rs2_val_r [RS_SIZE];
   logic [ROB_POS_W-1:0] rs1_tag_r [RS_SIZE];
   logic [ROB_POS_W-1:0] rs2_tag_r [RS_SIZE];
   logic [31:0]          imm_r     [RS_SIZE];
   logic [31:0]          pc_r      [RS_SIZE];
   logic [ROB_POS_W-1:0] rob_pos_r [RS_SIZE];

   logic [IDX_W-1:0]     free_idx_s;
   logic                 sel_found_s;
   logic [IDX_W-1:0]     sel_idx_s;
   logic                 iss_rs1_rdy_s;
   logic [31:0]          iss_rs1_val_s;
   logic                 iss_rs2_rdy_s;
   logic [31:0]          iss_rs2_val_s;

   // Full flag looks at registered busy bits only, so a slot freed by
   // dispatch becomes visible as free one cycle later.
   assign rs_full = &busy_r;

   // Lowest-index free slot and lowest-index ready entry (scan downwards so
   // the last hit is the lowest index).
   always_comb begin
      free_idx_s  = {IDX_W{1'b0}};
      sel_found_s = 1'b0;
      sel_idx_s   = {IDX_W{1'b0}};
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy_r[i]) begin
            free_idx_s = IDX_W'(i);
         end else if (rs1_rdy_r[i] && rs2_rdy_r[i]) begin
            sel_found_s = 1'b1;
            sel_idx_s   = IDX_W'(i);
         end else begin
         end
      end
   end

   // Operand values written at issue, optionally bypassed from a same-cycle broadcast.
   always_comb begin
      iss_rs1_rdy_s = issue_rs1_rdy;
      iss_rs1_val_s = issue_rs1_val;
      iss_rs2_rdy_s = issue_rs2_rdy;
      iss_rs2_val_s = issue_rs2_val;
`ifdef RS_FWD_ISSUE_EN
      if (!issue_rs1_rdy && alu_result && (alu_result_rob_pos == issue_rs1_tag)) begin
         iss_rs1_rdy_s = 1'b1;
         iss_rs1_val_s = alu_result_val;
      end else if (!issue_rs1_rdy && lsb_result && (lsb_result_rob_pos == issue_rs1_tag)) begin
         iss_rs1_rdy_s = 1'b1;
         iss_rs1_val_s = lsb_result_val;
      end else begin
      end
      if (!issue_rs2_rdy && alu_result && (alu_result_rob_pos == issue_rs2_tag)) begin
         iss_rs2_rdy_s = 1'b1;
         iss_rs2_val_s = alu_result_val;
      end else if (!issue_rs2_rdy && lsb_result && (lsb_result_rob_pos == issue_rs2_tag)) begin
         iss_rs2_rdy_s = 1'b1;
         iss_rs2_val_s = lsb_result_val;
      end else begin
      end
`endif
   end

   // Entry state: wakeup, dispatch and issue; registered ALU dispatch bundle.
   always_ff @(posedge clk) begin
      if (rst || rollback) begin
         busy_r  <= {RS_SIZE{1'b0}};
         alu_en  <= 1'b0;
         opcode  <= 7'd0;
         funct3  <= 3'd0;
         funct7  <= 1'b0;
         val1    <= 32'd0;
         val2    <= 32'd0;
         imm     <= 32'd0;
         pc      <= 32'd0;
         rob_pos <= {ROB_POS_W{1'b0}};
      end else if (rdy) begin
         // Tags are unique, so at most one broadcast can hit a given operand.
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_r[i] && !rs1_rdy_r[i]) begin
               if (alu_result && (alu_result_rob_pos == rs1_tag_r[i])) begin
                  rs1_rdy_r[i] <= 1'b1;
                  rs1_val_r[i] <= alu_result_val;
               end else if (lsb_result && (lsb_result_rob_pos == rs1_tag_r[i])) begin
                  rs1_rdy_r[i] <= 1'b1;
                  rs1_val_r[i] <= lsb_result_val;
               end else begin
               end
            end else begin
            end
            if (busy_r[i] && !rs2_rdy_r[i]) begin
               if (alu_result && (alu_result_rob_pos == rs2_tag_r[i])) begin
                  rs2_rdy_r[i] <= 1'b1;
                  rs2_val_r[i] <= alu_result_val;
               end else if (lsb_result && (lsb_result_rob_pos == rs2_tag_r[i])) begin
                  rs2_rdy_r[i] <= 1'b1;
                  rs2_val_r[i] <= lsb_result_val;
               end else begin
               end
            end else begin
            end
         end

         // Data outputs hold their last values when nothing is dispatched.
         if (sel_found_s) begin
            alu_en            <= 1'b1;
            opcode            <= opcode_r[sel_idx_s];
            funct3            <= funct3_r[sel_idx_s];
            funct7            <= funct7_r[sel_idx_s];
            val1              <= rs1_val_r[sel_idx_s];
            val2              <= rs2_val_r[sel_idx_s];
            imm               <= imm_r[sel_idx_s];
            pc                <= pc_r[sel_idx_s];
            rob_pos           <= rob_pos_r[sel_idx_s];
            busy_r[sel_idx_s] <= 1'b0;
         end else begin
            alu_en <= 1'b0;
         end

         // The free slot is never the dispatched one, so both updates coexist.
         if (issue && !rs_full) begin
            busy_r[free_idx_s]    <= 1'b1;
            opcode_r[free_idx_s]  <= issue_opcode;
            funct3_r[free_idx_s]  <= issue_funct3;
            funct7_r[free_idx_s]  <= issue_funct7;
            rs1_rdy_r[free_idx_s] <= iss_rs1_rdy_s;
            rs1_val_r[free_idx_s] <= iss_rs1_val_s;
            rs1_tag_r[free_idx_s] <= issue_rs1_tag;
            rs2_rdy_r[free_idx_s] <= iss_rs2_rdy_s;
            rs2_val_r[free_idx_s] <= iss_rs2_val_s;
            rs2_tag_r[free_idx_s] <= issue_rs2_tag;
            imm_r[free_idx_s]     <= issue_imm;
            pc_r[free_idx_s]      <= issue_pc;
            rob_pos_r[free_idx_s] <= issue_rob_pos;
         end else begin
         end
      end else begin
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// -----------------------------------------------------------------------------
// tb_alu_rs : self-checking bench for alu_rs (RS_SIZE 16, ROB_POS_W 4).
// A slot-level behavioural model predicts each dispatch and pushes it into a
// scoreboard queue; a negedge monitor pops and compares whenever alu_en is
// seen. Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_alu_rs;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback, issue;
   logic [3:0]  issue_rob_pos, issue_rs1_tag, issue_rs2_tag;
   logic [6:0]  issue_opcode;
   logic [2:0]  issue_funct3;
   logic        issue_funct7, issue_rs1_rdy, issue_rs2_rdy;
   logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
   logic        alu_result, lsb_result;
   logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
   logic [31:0] alu_result_val, lsb_result_val;
   logic        rs_full, alu_en, funct7;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] val1, val2, imm, pc;
   logic [3:0]  rob_pos;

   alu_rs #(.RS_SIZE(16), .ROB_POS_W(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .issue(issue),
      .issue_rob_pos(issue_rob_pos), .issue_opcode(issue_opcode),
      .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
      .issue_rs1_rdy(issue_rs1_rdy), .issue_rs1_val(issue_rs1_val),
      .issue_rs1_tag(issue_rs1_tag), .issue_rs2_rdy(issue_rs2_rdy),
      .issue_rs2_val(issue_rs2_val), .issue_rs2_tag(issue_rs2_tag),
      .issue_imm(issue_imm), .issue_pc(issue_pc),
      .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
      .alu_result_val(alu_result_val), .lsb_result(lsb_result),
      .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val),
      .rs_full(rs_full), .alu_en(alu_en), .opcode(opcode), .funct3(funct3),
      .funct7(funct7), .val1(val1), .val2(val2), .imm(imm), .pc(pc),
      .rob_pos(rob_pos)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] im;
      logic [31:0] pcv;
      logic [3:0]  rob;
   } rec_t;

   rec_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   started = 1'b0;

   // Behavioural model: one record per slot, plain arrays.
   bit          m_busy[16];
   bit          m_r1[16], m_r2[16];
   logic [31:0] m_v1[16], m_v2[16], m_im[16], m_pc[16];
   logic [3:0]  m_t1[16], m_t2[16], m_rob[16];
   logic [6:0]  m_op[16];
   logic [2:0]  m_f3[16];
   logic        m_f7[16];
   bit          m_en = 1'b0;
   bit          m_full = 1'b0;
   rec_t        m_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Wakeup of one operand from the broadcasts seen at this edge.
   task automatic wake(inout bit r, inout logic [31:0] v, input logic [3:0] t);
      if (!r && alu_result && alu_result_rob_pos == t) begin
         r = 1'b1; v = alu_result_val;
      end else if (!r && lsb_result && lsb_result_rob_pos == t) begin
         r = 1'b1; v = lsb_result_val;
      end
   endtask

   task automatic model_step();
      int sel, fr;
      bit full;
      rec_t r;
      if (rst || rollback) begin
         for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
         m_en = 1'b0;
         m_last = '{0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0};
      end else if (!rdy) begin
         if (m_en) begin
            r = m_last; r.cyc = cyc; exp_q.push_back(r);
         end
      end else begin
         sel = -1; fr = -1; full = 1'b1;
         for (int i = 0; i < 16; i++) begin
            if (m_busy[i] && m_r1[i] && m_r2[i] && sel < 0) sel = i;
            if (!m_busy[i]) begin
               full = 1'b0;
               if (fr < 0) fr = i;
            end
         end
         for (int i = 0; i < 16; i++) begin
            if (m_busy[i]) begin
               wake(m_r1[i], m_v1[i], m_t1[i]);
               wake(m_r2[i], m_v2[i], m_t2[i]);
            end
         end
         if (sel >= 0) begin
            r = '{cyc, m_op[sel], m_f3[sel], m_f7[sel], m_v1[sel], m_v2[sel],
                  m_im[sel], m_pc[sel], m_rob[sel]};
            exp_q.push_back(r);
            m_last = r; m_en = 1'b1; m_busy[sel] = 1'b0;
         end else begin
            m_en = 1'b0;
         end
         if (issue && !full) begin
            m_busy[fr] = 1'b1; m_op[fr] = issue_opcode; m_f3[fr] = issue_funct3;
            m_f7[fr] = issue_funct7; m_im[fr] = issue_imm; m_pc[fr] = issue_pc;
            m_rob[fr] = issue_rob_pos;
            m_r1[fr] = issue_rs1_rdy; m_v1[fr] = issue_rs1_val; m_t1[fr] = issue_rs1_tag;
            m_r2[fr] = issue_rs2_rdy; m_v2[fr] = issue_rs2_val; m_t2[fr] = issue_rs2_tag;
`ifdef RS_FWD_ISSUE_EN
            wake(m_r1[fr], m_v1[fr], m_t1[fr]);
            wake(m_r2[fr], m_v2[fr], m_t2[fr]);
`endif
         end
      end
      m_full = 1'b1;
      for (int i = 0; i < 16; i++) if (!m_busy[i]) m_full = 1'b0;
   endtask

   // Monitor: compare every presented dispatch against the scoreboard.
   always @(negedge clk) begin
      if (started) begin
         chk("rs_full", {31'd0, rs_full}, {31'd0, m_full});
         if (alu_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL spurious_dispatch: got alu_en=1 rob_pos=%h, expected none (cycle %0d)", rob_pos, cyc);
            end else begin
               rec_t e;
               e = exp_q.pop_front();
               chk("disp_cycle", cyc, e.cyc);
               chk("opcode", {25'd0, opcode}, {25'd0, e.op});
               chk("funct3", {29'd0, funct3}, {29'd0, e.f3});
               chk("funct7", {31'd0, funct7}, {31'd0, e.f7});
               chk("val1", val1, e.v1);
               chk("val2", val2, e.v2);
               chk("imm", imm, e.im);
               chk("pc", pc, e.pcv);
               chk("rob_pos", {28'd0, rob_pos}, {28'd0, e.rob});
            end
         end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            n_chk++; n_fail++;
            $display("FAIL missing_dispatch: got alu_en=%b, expected rob_pos=%h (cycle %0d)", alu_en, exp_q[0].rob, cyc);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; rdy = 1'b1; rollback = 1'b0; issue = 1'b0;
      alu_result = 1'b0; lsb_result = 1'b0;
   endtask

   task automatic set_issue(input logic [3:0] rob, input logic [6:0] op, input logic [2:0] f3,
                            input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                            input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                            input logic [31:0] im);
      issue = 1'b1; issue_rob_pos = rob; issue_opcode = op; issue_funct3 = f3;
      issue_funct7 = 1'b0; issue_rs1_rdy = r1; issue_rs1_val = v1; issue_rs1_tag = t1;
      issue_rs2_rdy = r2; issue_rs2_val = v2; issue_rs2_tag = t2; issue_imm = im;
      issue_pc = 32'h1000 + {26'd0, rob, 2'd0};
   endtask

   task automatic flush();
      idle(); rollback = 1'b1; tick(); idle();
   endtask

   initial begin
      idle();
      set_issue(4'd0, 7'd0, 3'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0);
      issue = 1'b0;
      alu_result_rob_pos = 4'd0; alu_result_val = 32'd0;
      lsb_result_rob_pos = 4'd0; lsb_result_val = 32'd0;
      rst = 1'b1;
      tick(); tick();
      idle();
      started = 1'b1;
      chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
      chk("rst_rs_full", {31'd0, rs_full}, 32'd0);
      chk("rst_val1", val1, 32'd0);
      chk("rst_pc", pc, 32'd0);
      chk("rst_rob_pos", {28'd0, rob_pos}, 32'd0);

      // ADD rob 3, both operands ready: dispatch after the second edge.
      set_issue(4'd3, 7'b0110011, 3'd0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 32'd0);
      tick(); idle(); tick();
      chk("add_alu_en", {31'd0, alu_en}, 32'd1);
      chk("add_val1", val1, 32'd5);
      chk("add_val2", val2, 32'd7);
      chk("add_opcode", {25'd0, opcode}, 32'h33);
      tick();
      chk("add_done", {31'd0, alu_en}, 32'd0);

      // ADDI rob 2 waiting on tag 1; broadcast three cycles later.
      set_issue(4'd2, 7'b0010011, 3'd0, 1'b0, 32'd0, 4'd1, 1'b1, 32'd0, 4'd0, 32'h20);
      tick(); idle(); tick(); tick();
      alu_result = 1'b1; alu_result_rob_pos = 4'd1; alu_result_val = 32'h10;
      tick(); idle();
      chk("addi_wait", {31'd0, alu_en}, 32'd0);
      tick();
      chk("addi_alu_en", {31'd0, alu_en}, 32'd1);
      chk("addi_val1", val1, 32'h10);
      tick();

      // Fill all 16 slots with waiting entries; extra issue ignored.
      for (int i = 0; i < 16; i++) begin
         set_issue(4'(i), 7'b0110011, 3'd0, 1'b0, 32'd0, 4'(i), 1'b1, 32'(i), 4'd0, 32'd0);
         tick();
      end
      chk("full_after_fill", {31'd0, rs_full}, 32'd1);
      set_issue(4'd9, 7'b0110011, 3'd1, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 32'd0);
      tick(); idle();
      chk("full_extra_ignored", {31'd0, rs_full}, 32'd1);
      alu_result = 1'b1; alu_result_rob_pos = 4'd5; alu_result_val = 32'h55;
      tick(); idle(); tick();
      chk("full_disp_rob", {28'd0, rob_pos}, 32'd5);
      chk("full_disp_val1", val1, 32'h55);
      chk("full_cleared", {31'd0, rs_full}, 32'd0);
      tick();
      chk("extra_not_stored", {31'd0, alu_en}, 32'd0);
      flush();

      // Entries 2 and 7 woken together: lowest index first.
      for (int i = 0; i < 8; i++) begin
         set_issue(4'(i), 7'b1100011, 3'd1, 1'b1, 32'(i), 4'd0, 1'b0, 32'd0,
                   (i == 2 || i == 7) ? 4'd9 : 4'd12, 32'h8);
         tick();
      end
      idle(); lsb_result = 1'b1; lsb_result_rob_pos = 4'd9; lsb_result_val = 32'h99;
      tick(); idle(); tick();
      chk("order_first", {28'd0, rob_pos}, 32'd2);
      tick();
      chk("order_second", {28'd0, rob_pos}, 32'd7);
      tick();
      flush();

      // Rollback drops waiting entries; later broadcasts wake nothing.
      for (int i = 0; i < 4; i++) begin
         set_issue(4'(i + 4), 7'b1101111, 3'd0, 1'b0, 32'd0, 4'd3, 1'b1, 32'd0, 4'd0, 32'd4);
         tick();
      end
      flush();
      chk("rb_alu_en", {31'd0, alu_en}, 32'd0);
      chk("rb_val1", val1, 32'd0);
      alu_result = 1'b1; alu_result_rob_pos = 4'd3; alu_result_val = 32'h33;
      tick(); idle(); tick(); tick();
      chk("rb_no_dispatch", {31'd0, alu_en}, 32'd0);

      // Issue-time forwarding from a same-cycle LSB broadcast.
      set_issue(4'd6, 7'b0010011, 3'd0, 1'b0, 32'd0, 4'd4, 1'b1, 32'd0, 4'd0, 32'd1);
      lsb_result = 1'b1; lsb_result_rob_pos = 4'd4; lsb_result_val = 32'hAB;
      tick(); idle(); tick();
`ifdef RS_FWD_ISSUE_EN
      chk("fwd_alu_en", {31'd0, alu_en}, 32'd1);
      chk("fwd_val1", val1, 32'hAB);
`else
      chk("nofwd_waiting", {31'd0, alu_en}, 32'd0);
`endif
      flush();

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         idle();
         rdy = ($urandom_range(0, 7) != 0);
         rollback = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 1) == 1) begin
            set_issue(4'($urandom_range(0, 15)), 7'($urandom), 3'($urandom),
                      1'($urandom), $urandom, 4'($urandom_range(0, 15)),
                      1'($urandom), $urandom, 4'($urandom_range(0, 15)), $urandom);
            issue_funct7 = 1'($urandom);
            issue_pc = $urandom;
         end
         alu_result = ($urandom_range(0, 2) == 0);
         alu_result_rob_pos = 4'($urandom_range(0, 15));
         alu_result_val = $urandom;
         lsb_result = ($urandom_range(0, 3) == 0);
         lsb_result_rob_pos = 4'($urandom_range(0, 15));
         lsb_result_val = $urandom;
         if (lsb_result_rob_pos == alu_result_rob_pos) lsb_result = 1'b0;
         tick();
      end
      idle(); tick(); tick();
      flush(); tick();
      @(negedge clk); #1;
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
